// File: rtl/aes32_fu.sv
// aes32_fu: two-stage pipelined functional unit for the RISC-V scalar AES
// instructions aes32esi / aes32esmi / aes32dsi / aes32dsmi.
// Stage 1 captures the operands and the selected rs2 byte; the S-box,
// partial MixColumn, rotate and XOR are computed from stage 1 into the
// registered result. Valid/ready handshakes on both sides, synchronous flush.
// Optional feature macro: AES32_FU_DEC_EN builds the inverse S-box and the
// decrypt MixColumn. Without it, decrypt requests complete with result = rs1.
module aes32_fu (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        valid,
  output logic        ready,
  input  logic        op_dec,
  input  logic        op_mix,
  input  logic [1:0]  bs,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result
);

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

`ifdef AES32_FU_DEC_EN
  // Inverse S-box: inverse affine transform followed by the inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction
`endif

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[7:0],  w[31:8]};
    endcase
    return r;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic        s1_dec_q, s1_mix_q;
  logic [1:0]  s1_bs_q;
  logic [31:0] s1_rs1_q;
  logic [7:0]  s1_x_q;
  logic        result_valid_q, result_valid_d;
  logic [31:0] result_q, result_d;

  logic        out_free;
  logic        s1_adv;
  logic        accept;
  logic [7:0]  sbox_out;
  logic [31:0] mix_word;
  logic [31:0] word;

  assign out_free     = !result_valid_q || result_ready;
  assign s1_adv       = s1_valid_q && out_free;
  assign ready        = !flush && (!s1_valid_q || out_free);
  assign accept       = valid && ready;
  assign result_valid = result_valid_q;
  assign result       = result_q;

  // Pipeline occupancy: flush wins, acceptance refills stage 1, advance empties it.
  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    s1_valid_d     = s1_valid_q;
    result_valid_d = result_valid_q;
    if (flush) begin
      s1_valid_d     = 1'b0;
      result_valid_d = 1'b0;
    end else begin
      if (accept)      s1_valid_d = 1'b1;
      else if (s1_adv) s1_valid_d = 1'b0;
      if (s1_adv)            result_valid_d = 1'b1;
      else if (result_ready) result_valid_d = 1'b0;
    end
  end

  // Datapath: substitute, optional partial MixColumn, rotate into place, XOR into rs1.
  always_comb begin
    sbox_out = fwd_sbox(s1_x_q);
    mix_word = {gf_mul(sbox_out, 8'h03), sbox_out, sbox_out, gf_mul(sbox_out, 8'h02)};
`ifdef AES32_FU_DEC_EN
    if (s1_dec_q) begin
      sbox_out = inv_sbox(s1_x_q);
      mix_word = {gf_mul(sbox_out, 8'h0B), gf_mul(sbox_out, 8'h0D),
                  gf_mul(sbox_out, 8'h09), gf_mul(sbox_out, 8'h0E)};
    end
    word = s1_mix_q ? mix_word : {24'h0, sbox_out};
`else
    word = s1_mix_q ? mix_word : {24'h0, sbox_out};
    if (s1_dec_q) word = 32'h0;
`endif
    result_d = s1_rs1_q ^ rotl_bytes(word, s1_bs_q);
  end

  // Control and result registers, cleared by the asynchronous reset.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!g_resetn) begin
      s1_valid_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= 32'h0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      result_valid_q <= result_valid_d;
      if (s1_adv && !flush) result_q <= result_d;
    end
  end

  // Stage-1 operand capture on acceptance.
  always_ff @(posedge g_clk) begin
    // NOTE: operand registers carry no reset; s1_valid_q qualifies them, so their power-up contents never escape.
    if (accept) begin
      s1_dec_q <= op_dec;
      s1_mix_q <= op_mix;
      s1_bs_q  <= bs;
      s1_rs1_q <= rs1;
      s1_x_q   <= rs2[{bs, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_aes32_fu.sv
// Directed self-checking bench for aes32_fu: reset state, the four
// instruction flavours, byte rotation, throughput, backpressure, flush and
// asynchronous reset. Decrypt expectations follow AES32_FU_DEC_EN.
module tb_aes32_fu;

  logic        g_clk;
  logic        g_resetn;
  logic        flush;
  logic        valid;
  logic        ready;
  logic        op_dec;
  logic        op_mix;
  logic [1:0]  bs;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

`ifdef AES32_FU_DEC_EN
  localparam logic [31:0] EXP_DSI  = 32'h00000053;
  localparam logic [31:0] EXP_DSMI = 32'h5BAAFD5F;
`else
  localparam logic [31:0] EXP_DSI  = 32'h00000000;
  localparam logic [31:0] EXP_DSMI = 32'h00000000;
`endif

  aes32_fu dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .flush        (flush),
    .valid        (valid),
    .ready        (ready),
    .op_dec       (op_dec),
    .op_mix       (op_mix),
    .bs           (bs),
    .rs1          (rs1),
    .rs2          (rs2),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] r1, input logic [31:0] r2,
                       input logic [1:0] b, input logic d, input logic m);
    valid  = 1'b1;
    rs1    = r1;
    rs2    = r2;
    bs     = b;
    op_dec = d;
    op_mix = m;
  endtask

  // One isolated request with result_ready=1: checks two-cycle latency and value.
  task automatic run_op(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [1:0] b, input logic d, input logic m,
                        input logic [31:0] exp);
    drive(r1, r2, b, d, m);
    #1;
    check({tag, " ready"}, {31'h0, ready}, 32'h1);
    tick();
    valid = 1'b0;
    check({tag, " not_early"}, {31'h0, result_valid}, 32'h0);
    tick();
    check({tag, " valid"}, {31'h0, result_valid}, 32'h1);
    check(tag, result, exp);
  endtask

  int accepted;

  initial begin
    g_resetn     = 1'b0;
    flush        = 1'b0;
    valid        = 1'b0;
    op_dec       = 1'b0;
    op_mix       = 1'b0;
    bs           = 2'd0;
    rs1          = 32'h0;
    rs2          = 32'h0;
    result_ready = 1'b1;

    // Reset state, observed while reset is held.
    #12;
    check("rst ready", {31'h0, ready}, 32'h1);
    check("rst valid", {31'h0, result_valid}, 32'h0);
    check("rst result", result, 32'h0);
    #5 g_resetn = 1'b1;
    tick();
    check("post_rst ready", {31'h0, ready}, 32'h1);

    // Instruction flavours.
    run_op("esi",        32'h00000000, 32'h00000053, 2'd0, 1'b0, 1'b0, 32'h000000ED);
    run_op("esmi_bs1",   32'h00000000, 32'h00005300, 2'd1, 1'b0, 1'b1, 32'hEDEDC12C);
    run_op("esmi_ones",  32'hFFFFFFFF, 32'h00005300, 2'd1, 1'b0, 1'b1, 32'h12123ED3);
    run_op("esi_bs3",    32'h12345678, 32'h01000000, 2'd3, 1'b0, 1'b0, 32'h6E345678);
    run_op("esmi_bs2",   32'h00000000, 32'hFF00FFFF, 2'd2, 1'b0, 1'b1, 32'h63C6A563);
    run_op("dsi",        32'h00000000, 32'h000000ED, 2'd0, 1'b1, 1'b0, EXP_DSI);
    run_op("dsmi",       32'h00000000, 32'h000000ED, 2'd0, 1'b1, 1'b1, EXP_DSMI);
    tick();
    check("drain", {31'h0, result_valid}, 32'h0);

    // Throughput: three back-to-back requests, results on consecutive cycles.
    drive(32'h00000001, 32'h00000053, 2'd0, 1'b0, 1'b0);
    tick();
    drive(32'h00000002, 32'h00000053, 2'd0, 1'b0, 1'b0);
    check("tput lat", {31'h0, result_valid}, 32'h0);
    tick();
    drive(32'h00000003, 32'h00000053, 2'd0, 1'b0, 1'b0);
    check("tput r0", result, 32'h000000EC);
    tick();
    valid = 1'b0;
    check("tput r1", result, 32'h000000EF);
    tick();
    check("tput r2", result, 32'h000000EE);
    check("tput r2 valid", {31'h0, result_valid}, 32'h1);
    tick();
    check("tput end", {31'h0, result_valid}, 32'h0);

    // Backpressure: four requests offered with result_ready=0, only two accepted.
    result_ready = 1'b0;
    accepted     = 0;
    drive(32'h00000000, 32'h00000053, 2'd0, 1'b0, 1'b0);
    #1 if (ready) accepted++;
    tick();
    drive(32'h000000FF, 32'h00000053, 2'd0, 1'b0, 1'b0);
    #1 if (ready) accepted++;
    tick();
    drive(32'hAAAAAAAA, 32'h00000053, 2'd0, 1'b0, 1'b0);
    #1 if (ready) accepted++;
    tick();
    check("bp hold0", result, 32'h000000ED);
    drive(32'h55555555, 32'h00000053, 2'd0, 1'b0, 1'b0);
    #1 if (ready) accepted++;
    check("bp ready", {31'h0, ready}, 32'h0);
    tick();
    check("bp accepted", accepted, 32'd2);
    check("bp hold1", result, 32'h000000ED);
    check("bp valid", {31'h0, result_valid}, 32'h1);
    valid        = 1'b0;
    result_ready = 1'b1;
    tick();
    check("bp second", result, 32'h00000012);
    check("bp second valid", {31'h0, result_valid}, 32'h1);
    tick();
    check("bp drained", {31'h0, result_valid}, 32'h0);

    // Flush with two operations in flight and a request offered.
    result_ready = 1'b0;
    drive(32'h00000000, 32'h00000053, 2'd0, 1'b0, 1'b0);
    tick();
    drive(32'h00000001, 32'h00000053, 2'd0, 1'b0, 1'b0);
    tick();
    drive(32'h00000002, 32'h00000053, 2'd0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush ready_low", {31'h0, ready}, 32'h0);
    tick();
    flush = 1'b0;
    valid = 1'b0;
    check("flush valid", {31'h0, result_valid}, 32'h0);
    #1;
    check("flush ready", {31'h0, ready}, 32'h1);
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush no_stale", {31'h0, result_valid}, 32'h0);
    end

    // Asynchronous reset with a result held at the output.
    result_ready = 1'b0;
    drive(32'h00000000, 32'h00000053, 2'd0, 1'b0, 1'b0);
    tick();
    valid = 1'b0;
    tick();
    check("arst pre", result, 32'h000000ED);
    #2 g_resetn = 1'b0;
    #1;
    check("arst valid", {31'h0, result_valid}, 32'h0);
    check("arst result", result, 32'h0);
    check("arst ready", {31'h0, ready}, 32'h1);
    #3 g_resetn = 1'b1;
    result_ready = 1'b1;
    tick();
    tick();
    check("arst no_stale", {31'h0, result_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes32_fu.md
# aes32_fu

Pipelined functional unit implementing the RISC-V scalar AES instructions aes32esi, aes32esmi, aes32dsi and aes32dsmi. It sits directly downstream of the issue stage and upstream of writeback. It is the consumer of the single-byte forward/inverse S-box: it selects one byte of rs2, substitutes it, and optionally applies the partial MixColumn. It then rotates the 32-bit word into position and XORs it into rs1. It is a two-stage pipeline with valid/ready handshakes on both sides and a synchronous flush.

## Interface
Parameters: none.

Ports:
- g_clk — in, 1 — clock. All state changes on the rising edge.
- g_resetn — in, 1 — reset; asynchronous, active-low.
- flush — in, 1 — synchronous flush; discards all in-flight operations.
- valid — in, 1 — request valid.
- ready — out, 1 — unit can accept a request this cycle.
- op_dec — in, 1 — 0 selects encrypt (forward S-box); 1 selects decrypt (inverse S-box).
- op_mix — in, 1 — 1 applies the partial MixColumn (esmi/dsmi); 0 does not (esi/dsi).
- bs — in, 2 — byte select; rs2 byte index 0..3.
- rs1 — in, 32 — accumulator operand.
- rs2 — in, 32 — source word.
- result_valid — out, 1 — result available.
- result_ready — in, 1 — downstream accepts the result.
- result — out, 32 — instruction result.

## Operation
- Accept: a request is accepted when valid && ready on a rising edge. At acceptance, stage 1 captures op_dec, op_mix, bs, rs1, and the selected byte x = rs2[8*bs+7:8*bs].
- Stage 1 → output computation:
  - s = fwd_sbox(x) if op_dec=0; s = inv_sbox(x) if op_dec=1.
  - Encrypt, op_mix=1: w = {3·s, s, s, 2·s}, with bytes listed MSB first.
  - Decrypt, op_mix=1: w = {0B·s, 0D·s, 09·s, 0E·s}.
  - op_mix=0: w = {24'h0, s}.
  - All multiplications are GF(2^8) with polynomial 0x11B.
  - result = rs1 ^ rotl32(w, 8*bs).
- Output register:
  - result and result_valid are registered.
  - The result holds stable while result_valid && !result_ready.
- Advance rules:
  - out_free = !result_valid || result_ready.
  - Stage 1 moves to the output register when s1_valid && out_free.
  - ready = !flush && (!s1_valid || out_free). ready is combinational.
- Flush:
  - On an edge with flush=1, s1_valid and result_valid clear.
  - No request is accepted on that edge, even if valid=1.
  - result data is don't-care after a flush.
- Simultaneous events:
  - If result_ready, a stage-1 advance, and a new acceptance all occur on the same edge, all three take effect: output replaced, stage 1 reloaded.
  - flush overrides all of them.

## Timing
- Reset values: s1_valid=0, result_valid=0, result=32'h0. ready=1 during and after reset (while flush=0).
- Latency: a request accepted at edge N presents result_valid=1 after edge N+1, i.e. 2 cycles.
- Throughput: 1 operation per cycle while result_ready=1.
- Buffering depth: 2. With result_ready=0, at most two operations are held and ready drops to 0.
- Asynchronous reset mid-operation: in-flight work is dropped immediately, with no partial result.
- Critical path: stage-1 register → S-box → GF multiply → rotate → XOR → result register. There is no combinational path from valid/rs* to result.

## Configuration
- AES32_FU_DEC_EN defined: the inverse S-box and decrypt MixColumn paths are built, and all four instructions are supported.
- AES32_FU_DEC_EN undefined: the inverse S-box and decrypt MixColumn logic are omitted.
  - Requests with op_dec=1 are still accepted and complete with normal timing.
  - Their result equals rs1 unchanged.
  - Encrypt behaviour is identical in both builds.

## Test plan
- esi: rs1=0, rs2=32'h00000053, bs=0, op_dec=0, op_mix=0 → result 32'h000000ED, 2 cycles after acceptance.
- esmi with rotation: rs1=0, rs2=32'h00005300, bs=1, op_mix=1 → result 32'hEDEDC12C. Repeat with rs1=32'hFFFFFFFF → 32'h12123ED3.
- dsi / dsmi (AES32_FU_DEC_EN defined):
  - rs1=0, rs2=32'h000000ED, bs=0, op_dec=1, op_mix=0 → 32'h00000053.
  - Same request with op_mix=1 → 32'h5BAAFD5F.
  - Build without AES32_FU_DEC_EN: same requests → result 32'h00000000, equal to rs1.
- Backpressure:
  - Issue 4 back-to-back requests with result_ready=0 → exactly 2 accepted, ready=0, result stable.
  - Raise result_ready → results emerge in order, one per cycle, with no loss or duplication.
- Flush and reset:
  - Assert flush with 2 ops in flight and valid=1 → next cycle result_valid=0, ready=1, the flush-cycle request is not accepted, and no stale result later appears.
  - Assert g_resetn=0 asynchronously mid-stream → result_valid and result go to 0 without waiting for a clock edge.
